kf76489_write_sequencer: RTL

//  Host-side bus initiator for the KF76489 sound core. Queues register-write commands,

---
 rtl/kf76489_write_sequencer_if.sv | 26 ++
 rtl/kf76489_write_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/kf76489_write_sequencer_if.sv
// Command handshake and KF76489 write-bus signals shared by the sequencer and its peers.
interface kf76489_write_sequencer_if;
    // command source side
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_channel;
    logic       cmd_atten;
    logic [9:0] cmd_data;
    // KF76489 pin side
    logic       CE_N;
    logic       WE_N;
    logic [7:0] D_OUT;
    logic       READY;

    // the sequencer: accepts commands, initiates bus writes
    modport master (
        input  cmd_valid, cmd_channel, cmd_atten, cmd_data, READY,
        output cmd_ready, CE_N, WE_N, D_OUT
    );

    // command source / sound core model
    modport slave (
        output cmd_valid, cmd_channel, cmd_atten, cmd_data, READY,
        input  cmd_ready, CE_N, WE_N, D_OUT
    );
endinterface

// File: rtl/kf76489_write_sequencer.sv
// KF76489 write sequencer: command FIFO, latch/data byte encoder and a
// SETUP/STROBE/RECOVER/GAP timing FSM driving registered CE_N/WE_N/D_OUT.
module kf76489_write_sequencer #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int READY_TIMEOUT = 255
) (
    input  logic                         clock,
    input  logic                         reset_n,
    kf76489_write_sequencer_if.master    bus,
    input  logic                         err_clear,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

    // phase counter must hold the longest phase length minus one
    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_B = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int MAX_C = (MAX_B > READY_TIMEOUT) ? MAX_B : READY_TIMEOUT;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(READY_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_RECOVER = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    // FIFO entry layout: {channel[1:0], atten, data[9:0]}
    logic [12:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    cur_byte;
    logic [7:0]    next_byte;
    logic          second_pending;

    logic [12:0]   head;
    logic [1:0]    head_ch;
    logic          head_atten;
    logic [9:0]    head_data;
    logic [7:0]    enc_byte0;
    logic [7:0]    enc_byte1;
    logic          enc_two;

    assign bus.cmd_ready = reset_n && (fifo_count != FULL_COUNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == S_IDLE) && (fifo_count != '0);
    assign busy          = (state != S_IDLE) || (fifo_count != '0);

    // FIFO storage: written on accepted push, no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_channel, bus.cmd_atten, bus.cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Encode the FIFO head into its latch byte and optional data byte
    always_comb begin
        head       = fifo_mem[rd_ptr];
        head_ch    = head[12:11];
        head_atten = head[10];
        head_data  = head[9:0];
        enc_byte0  = '0;
        enc_byte1  = '0;
        enc_two    = 1'b0;
        if (head_atten) begin
            enc_byte0 = {1'b1, head_ch, 1'b1, head_data[3:0]};
        end else if (head_ch == 2'b11) begin
            enc_byte0 = {1'b1, 2'b11, 1'b0, 1'b0, head_data[2:0]};
        end else begin
            enc_byte0 = {1'b1, head_ch, 1'b0, head_data[3:0]};
            enc_byte1 = {2'b00, head_data[9:4]};
            enc_two   = 1'b1;
        end
    end

    // Bus timing FSM with phase counter, byte holding registers and sticky timeout flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            cur_byte       <= '0;
            next_byte      <= '0;
            second_pending <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            // a timeout set later in this block overrides the clear
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (fifo_count != '0) begin
                        cur_byte       <= enc_byte0;
                        next_byte      <= enc_byte1;
                        second_pending <= enc_two;
                        cnt            <= '0;
                        state          <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= S_STROBE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STROBE: begin
                    if ((cnt >= STROBE_LAST) && bus.READY) begin
                        cnt   <= '0;
                        state <= S_RECOVER;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout_err    <= 1'b1;
                        second_pending <= 1'b0;
                        cnt            <= '0;
                        state          <= S_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RECOVER: begin
                    cnt   <= '0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        if (second_pending) begin
                            cur_byte       <= next_byte;
                            second_pending <= 1'b0;
                            state          <= S_SETUP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered pins follow the state one cycle later, so each phase keeps its
    // length while the pins stay glitch-free
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.CE_N  <= 1'b1;
            bus.WE_N  <= 1'b1;
            bus.D_OUT <= '0;
        end else begin
            bus.CE_N <= !((state == S_SETUP) || (state == S_STROBE) || (state == S_RECOVER));
            bus.WE_N <= !(state == S_STROBE);
            if (state == S_SETUP) begin
                bus.D_OUT <= cur_byte;
            end
        end
    end

endmodule
